// File: rtl/upstream_arbiter.sv
// Round-robin arbiter granting N_REQ clients serialized access to the upstream trade/order memory.
// Define UPSTREAM_ARB_TIMEOUT_EN to add a write-completion watchdog (WR_TIMEOUT cycles in WAIT).
module upstream_arbiter #(
   parameter int unsigned N_REQ      = 2,
   parameter int unsigned IDX_W      = 7,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_DEPTH  = 122,
   parameter int unsigned WR_TIMEOUT = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_rw,
   input  logic [N_REQ-1:0]          req_change_max,
   input  logic [N_REQ*IDX_W-1:0]    req_index,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          req_grant,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   output logic [IDX_W-1:0]          mem_index,
   output logic                      mem_wr_strobe,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic                      mem_change_max,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_rd_ready,
   input  logic                      mem_written,
   output logic                      busy,
   output logic [15:0]               txn_count
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {IDLE, RD, WR, WAIT, RESP} state_t;

   if (WR_TIMEOUT == 0) begin : g_bad_cfg
      $error("upstream_arbiter: WR_TIMEOUT must be nonzero");
   end

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    id_q, id_d;
   logic                err_q, err_d;
   logic                seen_low_q, seen_low_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [N_REQ-1:0]    req_grant_d, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_d, mem_wdata_d;
   logic                rsp_err_d, mem_wr_strobe_d, mem_change_max_d, busy_d;
   logic [IDX_W-1:0]    mem_index_d;
   logic [15:0]         txn_count_d;

   logic                grant_found;
   logic [PTR_W-1:0]    grant_id;
   logic [IDX_W-1:0]    sel_index;
   logic [DATA_W-1:0]   sel_wdata;

`ifdef UPSTREAM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

   // Round-robin pick: first valid requester at or after the pointer.
   always_comb begin : arb_pick
      int unsigned      cand;
      logic [PTR_W-1:0] cand_p;
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = 0;
      cand_p      = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand   = (32'(ptr_q) + k) % N_REQ;
         cand_p = PTR_W'(cand);
         if (!grant_found && req_valid[cand_p]) begin
            grant_found = 1'b1;
            grant_id    = cand_p;
         end
      end
   end

   assign sel_index = req_index[32'(grant_id)*IDX_W +: IDX_W];
   assign sel_wdata = req_wdata[32'(grant_id)*DATA_W +: DATA_W];

   // Next state and next values of all registered outputs.
   always_comb begin : fsm_next
      state_d          = state_q;
      ptr_d            = ptr_q;
      id_d             = id_q;
      err_d            = err_q;
      seen_low_d       = seen_low_q;
      rdata_d          = rdata_q;
      req_grant_d      = '0;
      rsp_valid_d      = '0;
      rsp_rdata_d      = rsp_rdata;
      rsp_err_d        = rsp_err;
      mem_index_d      = mem_index;
      mem_wdata_d      = mem_wdata;
      mem_change_max_d = mem_change_max;
      mem_wr_strobe_d  = 1'b0;
      txn_count_d      = txn_count;
`ifdef UPSTREAM_ARB_TIMEOUT_EN
      cnt_d            = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (grant_found) begin
               req_grant_d[grant_id] = 1'b1;
               id_d       = grant_id;
               ptr_d      = (grant_id == PTR_W'(N_REQ-1)) ? '0 : grant_id + PTR_W'(1);
               rdata_d    = '0;
               seen_low_d = 1'b0;
`ifdef UPSTREAM_ARB_TIMEOUT_EN
               cnt_d      = '0;
`endif
               if (txn_count != 16'hFFFF) txn_count_d = txn_count + 16'd1;
               if (32'(sel_index) >= MEM_DEPTH) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d            = 1'b0;
                  mem_index_d      = sel_index;
                  mem_wdata_d      = sel_wdata;
                  mem_change_max_d = req_change_max[grant_id];
                  state_d          = req_rw[grant_id] ? WR : RD;
               end
            end
         end
         RD: begin
            if (mem_rd_ready) begin
               rdata_d = mem_rdata;
               state_d = RESP;
            end
         end
         WR: begin
            mem_wr_strobe_d = 1'b1;
            state_d         = WAIT;
         end
         WAIT: begin
            // A high level only counts once a low has been seen after the strobe.
            if (mem_written && seen_low_q) begin
               state_d = RESP;
            end
`ifdef UPSTREAM_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(WR_TIMEOUT-1)) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
            if (!mem_written) seen_low_d = 1'b1;
         end
         RESP: begin
            rsp_valid_d[id_q] = 1'b1;
            rsp_rdata_d       = rdata_q;
            rsp_err_d         = err_q;
            state_d           = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         id_q           <= '0;
         err_q          <= 1'b0;
         seen_low_q     <= 1'b0;
         rdata_q        <= '0;
         req_grant      <= '0;
         rsp_valid      <= '0;
         rsp_rdata      <= '0;
         rsp_err        <= 1'b0;
         mem_index      <= '0;
         mem_wr_strobe  <= 1'b0;
         mem_wdata      <= '0;
         mem_change_max <= 1'b0;
         busy           <= 1'b0;
         txn_count      <= '0;
`ifdef UPSTREAM_ARB_TIMEOUT_EN
         cnt_q          <= '0;
`endif
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         id_q           <= id_d;
         err_q          <= err_d;
         seen_low_q     <= seen_low_d;
         rdata_q        <= rdata_d;
         req_grant      <= req_grant_d;
         rsp_valid      <= rsp_valid_d;
         rsp_rdata      <= rsp_rdata_d;
         rsp_err        <= rsp_err_d;
         mem_index      <= mem_index_d;
         mem_wr_strobe  <= mem_wr_strobe_d;
         mem_wdata      <= mem_wdata_d;
         mem_change_max <= mem_change_max_d;
         busy           <= busy_d;
         txn_count      <= txn_count_d;
`ifdef UPSTREAM_ARB_TIMEOUT_EN
         cnt_q          <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_upstream_arbiter.sv
// Directed self-checking bench for upstream_arbiter: read, write, stale-high, contention,
// range error, WAIT timeout/hang (depends on UPSTREAM_ARB_TIMEOUT_EN) and reset in WAIT.
module tb_upstream_arbiter;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    req_valid = '0, req_rw = '0, req_change_max = '0;
   logic [13:0]   req_index = '0;
   logic [63:0]   req_wdata = '0;
   logic [1:0]    req_grant, rsp_valid;
   logic [31:0]   rsp_rdata, mem_wdata;
   logic          rsp_err, mem_wr_strobe, mem_change_max, busy;
   logic [6:0]    mem_index;
   logic [31:0]   mem_rdata = '0;
   logic          mem_rd_ready = 1'b0, mem_written = 1'b1;
   logic [15:0]   txn_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   upstream_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_rw(req_rw), .req_change_max(req_change_max),
      .req_index(req_index), .req_wdata(req_wdata),
      .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_index(mem_index), .mem_wr_strobe(mem_wr_strobe), .mem_wdata(mem_wdata),
      .mem_change_max(mem_change_max), .mem_rdata(mem_rdata), .mem_rd_ready(mem_rd_ready),
      .mem_written(mem_written), .busy(busy), .txn_count(txn_count)
   );

   // Waits up to 20 cycles for a grant pulse; inputs change and outputs are sampled at negedge.
   task automatic wait_grant(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_grant != 2'b00) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({req_grant, rsp_valid, rsp_rdata, rsp_err, mem_index, mem_wr_strobe, mem_wdata,
           mem_change_max, busy, txn_count} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: grant=%b rsp=%b rdata=%h err=%b idx=%0d strb=%b wdata=%h cm=%b busy=%b txn=%0d, all required 0",
                  req_grant, rsp_valid, rsp_rdata, rsp_err, mem_index, mem_wr_strobe, mem_wdata,
                  mem_change_max, busy, txn_count);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || req_grant !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_idle: busy=%b grant=%b, required 0/00", busy, req_grant);
      end
   endtask

   task automatic test_read;
      bit found;
      req_index = {7'd0, 7'd5}; req_rw = 2'b00; req_valid = 2'b01;
      mem_rd_ready = 1'b1; mem_rdata = 32'h0064_0010;
      wait_grant(found);
      n_cmp++;
      if (!found || req_grant !== 2'b01) begin
         n_bad++; $display("FAIL read_grant: got %b, required 01", req_grant);
      end
      req_valid = 2'b00; req_index = {7'd0, 7'd100};
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 2'b00 || mem_index !== 7'd5) begin
         n_bad++; $display("FAIL read_t1: rsp=%b idx=%0d, required 00/5", rsp_valid, mem_index);
      end
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0064_0010 || rsp_err !== 1'b0) begin
         n_bad++;
         $display("FAIL read_rsp: rsp=%b rdata=%h err=%b, required 01/00640010/0", rsp_valid, rsp_rdata, rsp_err);
      end
      n_cmp++;
      if (txn_count !== 16'd1) begin
         n_bad++; $display("FAIL read_txn: got %0d, required 1", txn_count);
      end
   endtask

   task automatic test_write;
      bit found;
      int strobes = 0;
      mem_written = 1'b1; mem_rd_ready = 1'b0;
      req_index = {7'd3, 7'd0}; req_wdata = {32'h0000_000A, 32'h0};
      req_rw = 2'b10; req_change_max = 2'b00; req_valid = 2'b10;
      wait_grant(found);
      n_cmp++;
      if (!found || req_grant !== 2'b10) begin
         n_bad++; $display("FAIL write_grant: got %b, required 10", req_grant);
      end
      req_valid = 2'b00;
      if (mem_wr_strobe) strobes++;
      @(negedge clk);  // T+1
      if (mem_wr_strobe) strobes++;
      n_cmp++;
      if (mem_wr_strobe !== 1'b1 || mem_index !== 7'd3 || mem_wdata !== 32'h0000_000A || mem_change_max !== 1'b0) begin
         n_bad++;
         $display("FAIL write_cmd: strb=%b idx=%0d wdata=%h cm=%b, required 1/3/0000000a/0",
                  mem_wr_strobe, mem_index, mem_wdata, mem_change_max);
      end
      mem_written = 1'b0;
      repeat (3) begin
         @(negedge clk);  // T+2..T+4
         if (mem_wr_strobe) strobes++;
      end
      mem_written = 1'b1;
      @(negedge clk);  // T+5
      if (mem_wr_strobe) strobes++;
      n_cmp++;
      if (rsp_valid !== 2'b00 || mem_wdata !== 32'h0000_000A) begin
         n_bad++; $display("FAIL write_t5: rsp=%b wdata=%h, required 00/0000000a", rsp_valid, mem_wdata);
      end
      @(negedge clk);  // T+6
      n_cmp++;
      if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL write_rsp: rsp=%b err=%b rdata=%h, required 10/0/00000000", rsp_valid, rsp_err, rsp_rdata);
      end
      n_cmp++;
      if (strobes != 1) begin
         n_bad++; $display("FAIL write_strobe_count: got %0d, required 1", strobes);
      end
   endtask

   task automatic test_stale_high;
      bit found;
      int early = 0;
      mem_written = 1'b1;
      req_index = {7'd0, 7'd9}; req_wdata = {32'h0, 32'h1234_0000};
      req_rw = 2'b01; req_change_max = 2'b01; req_valid = 2'b01;
      wait_grant(found);
      n_cmp++;
      if (!found || req_grant !== 2'b01) begin
         n_bad++; $display("FAIL stale_grant: got %b, required 01", req_grant);
      end
      req_valid = 2'b00;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid != 2'b00 || !busy) early++;
      end
      n_cmp++;
      if (early != 0 || mem_change_max !== 1'b1) begin
         n_bad++; $display("FAIL stale_ignored: early=%0d cm=%b, required 0/1", early, mem_change_max);
      end
      mem_written = 1'b0;
      @(negedge clk);
      mem_written = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) begin
         n_bad++; $display("FAIL stale_rsp: rsp=%b err=%b, required 01/0", rsp_valid, rsp_err);
      end
   endtask

   task automatic test_contention;
      bit found;
      logic [1:0] exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      req_index = {7'd2, 7'd1}; req_rw = 2'b00; req_valid = 2'b11;
      mem_rd_ready = 1'b1; mem_rdata = 32'hCAFE_0042;
      for (int i = 0; i < 4; i++) begin
         wait_grant(found);
         n_cmp++;
         if (!found || req_grant !== exp_order[i]) begin
            n_bad++; $display("FAIL contention_grant%0d: got %b, required %b", i, req_grant, exp_order[i]);
         end
         if (i == 3) req_valid = 2'b00;
         repeat (2) @(negedge clk);
         n_cmp++;
         if (rsp_valid !== exp_order[i] || rsp_rdata !== 32'hCAFE_0042) begin
            n_bad++;
            $display("FAIL contention_rsp%0d: rsp=%b rdata=%h, required %b/cafe0042", i, rsp_valid, rsp_rdata, exp_order[i]);
         end
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (txn_count !== 16'd4 || busy !== 1'b0) begin
         n_bad++; $display("FAIL contention_txn: txn=%0d busy=%b, required 4/0", txn_count, busy);
      end
   endtask

   task automatic test_range;
      bit found;
      int strobes = 0;
      req_index = {7'd0, 7'd122}; req_rw = 2'b00; req_valid = 2'b01;
      wait_grant(found);
      n_cmp++;
      if (!found || req_grant !== 2'b01 || busy !== 1'b1) begin
         n_bad++; $display("FAIL range_grant: grant=%b busy=%b, required 01/1", req_grant, busy);
      end
      req_valid = 2'b00;
      if (mem_wr_strobe) strobes++;
      @(negedge clk);
      if (mem_wr_strobe) strobes++;
      n_cmp++;
      if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || strobes != 0) begin
         n_bad++;
         $display("FAIL range_rsp: rsp=%b err=%b rdata=%h strobes=%0d, required 01/1/00000000/0",
                  rsp_valid, rsp_err, rsp_rdata, strobes);
      end
   endtask

   task automatic test_timeout;
      bit found;
      int bad_cycles = 0;
      mem_written = 1'b0; mem_rd_ready = 1'b0;
      req_index = {7'd4, 7'd0}; req_wdata = {32'h0001_0000, 32'h0};
      req_rw = 2'b10; req_change_max = 2'b10; req_valid = 2'b10;
      wait_grant(found);
      n_cmp++;
      if (!found || req_grant !== 2'b10) begin
         n_bad++; $display("FAIL timeout_grant: got %b, required 10", req_grant);
      end
      req_valid = 2'b00;
`ifdef UPSTREAM_ARB_TIMEOUT_EN
      repeat (9) begin
         @(negedge clk);
         if (rsp_valid != 2'b00) bad_cycles++;
      end
      @(negedge clk);  // WR at T, WAIT T+1..T+8, RESP T+9, pulse T+10
      n_cmp++;
      if (bad_cycles != 0 || rsp_valid !== 2'b10 || rsp_err !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_rsp: early=%0d rsp=%b err=%b, required 0/10/1", bad_cycles, rsp_valid, rsp_err);
      end
`else
      repeat (40) begin
         @(negedge clk);
         if (rsp_valid != 2'b00 || !busy) bad_cycles++;
      end
      n_cmp++;
      if (bad_cycles != 0) begin
         n_bad++; $display("FAIL wait_hang: %0d cycles idle or responding, required 0", bad_cycles);
      end
`endif
   endtask

   task automatic test_reset_in_wait;
      bit found;
      int pulses = 0;
      if (!busy) begin
         mem_written = 1'b0;
         req_index = {7'd0, 7'd6}; req_rw = 2'b01; req_valid = 2'b01;
         wait_grant(found);
         req_valid = 2'b00;
         repeat (3) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || txn_count !== 16'd0 || rsp_valid !== 2'b00) begin
         n_bad++;
         $display("FAIL rst_wait: busy=%b txn=%0d rsp=%b, required 0/0/00", busy, txn_count, rsp_valid);
      end
      mem_written = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid != 2'b00) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_bad++; $display("FAIL rst_no_rsp: %0d pulses, required 0", pulses);
      end
      req_index = {7'd8, 7'd7}; req_rw = 2'b00; req_valid = 2'b11;
      mem_rd_ready = 1'b1; mem_rdata = 32'h0000_0777;
      wait_grant(found);
      n_cmp++;
      if (!found || req_grant !== 2'b01) begin
         n_bad++; $display("FAIL rst_first_grant: got %b, required 01", req_grant);
      end
      req_valid = 2'b00;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0000_0777 || txn_count !== 16'd1) begin
         n_bad++;
         $display("FAIL rst_after_rsp: rsp=%b rdata=%h txn=%0d, required 01/00000777/1", rsp_valid, rsp_rdata, txn_count);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_stale_high();
      test_contention();
      test_range();
      test_timeout();
      test_reset_in_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule
